// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues sequential fetches, tracks in-flight requests,
// buffers returned words with their PCs, and discards stale responses after a redirect.
module ifu_prefetch #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     DEPTH     = 4
) (
  input  logic            i_clk,
  input  logic            rst,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [31:0]     i_mem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_insn_vld,
  output logic [31:0]     o_insn,
  output logic [XLEN-1:0] o_insn_pc,
  input  logic            i_insn_rdy,
  output logic [XLEN-1:0] o_pc_debug,
  output logic            o_err
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
  } ent_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflt_q, inflt_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic [AW-1:0]   bhd_q, bhd_d, btl_q, btl_d;
  logic [AW-1:0]   qhd_q, qhd_d, qtl_q, qtl_d;
  logic            err_q, err_d;

  ent_t            buf_mem [DEPTH];
  logic [XLEN-1:0] pcq_mem [DEPTH];

  logic [CW:0]     occ;
  logic            fire, rv_acc, rv_keep, pop;
  logic            unused_rpc_lo;

  assign unused_rpc_lo = ^i_redirect_pc[1:0];

  // Buffer space is reserved at request time, so occupancy counts in-flight words too.
  always_comb begin
    occ       = {1'b0, inflt_q} + {1'b0, bcnt_q};
    o_mem_req = rst && (occ < (CW+1)'(DEPTH));
    fire      = o_mem_req && i_mem_gnt;
    rv_acc    = rst && i_mem_rvalid && (inflt_q != '0);
    rv_keep   = rv_acc && !i_redirect && (drop_q == '0);
    pop       = o_insn_vld && i_insn_rdy && !i_redirect;
  end

  always_comb begin
    pc_d = pc_q;
    if (i_redirect)
      pc_d = {i_redirect_pc[XLEN-1:2], 2'b00};
    else if (fire)
      pc_d = pc_q + XLEN'(4);

    inflt_d = inflt_q + CW'(fire) - CW'(rv_acc);

    // Everything still outstanding after a redirect belongs to the old path.
    drop_d = drop_q;
    if (i_redirect)
      drop_d = inflt_d;
    else if (rv_acc && (drop_q != '0))
      drop_d = drop_q - CW'(1);

    err_d = err_q | (i_mem_rvalid && (inflt_q == '0));

    qhd_d  = qhd_q;
    qtl_d  = qtl_q;
    bhd_d  = bhd_q;
    btl_d  = btl_q;
    bcnt_d = bcnt_q;
    if (i_redirect) begin
      qhd_d  = '0;
      qtl_d  = '0;
      bhd_d  = '0;
      btl_d  = '0;
      bcnt_d = '0;
    end else begin
      if (fire)    qtl_d = qtl_q + AW'(1);
      if (rv_keep) qhd_d = qhd_q + AW'(1);
      if (rv_keep) btl_d = btl_q + AW'(1);
      if (pop)     bhd_d = bhd_q + AW'(1);
      bcnt_d = bcnt_q + CW'(rv_keep) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      pc_q    <= RESET_VEC;
      inflt_q <= '0;
      drop_q  <= '0;
      bcnt_q  <= '0;
      bhd_q   <= '0;
      btl_q   <= '0;
      qhd_q   <= '0;
      qtl_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inflt_q <= inflt_d;
      drop_q  <= drop_d;
      bcnt_q  <= bcnt_d;
      bhd_q   <= bhd_d;
      btl_q   <= btl_d;
      qhd_q   <= qhd_d;
      qtl_q   <= qtl_d;
      err_q   <= err_d;
    end
  end

  // Storage needs no reset: pointers and counts qualify every read.
  always_ff @(posedge i_clk) begin
    if (fire && !i_redirect)
      pcq_mem[qtl_q] <= pc_q;
    if (rv_keep)
      buf_mem[btl_q] <= '{pc: pcq_mem[qhd_q], insn: i_mem_rdata};
  end

  assign o_mem_addr = pc_q;
  assign o_pc_debug = pc_q;
  assign o_insn_vld = (bcnt_q != '0);
  assign o_insn     = buf_mem[bhd_q].insn;
  assign o_insn_pc  = buf_mem[bhd_q].pc;
  assign o_err      = err_q;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: in-order memory model plus a scoreboard of expected
// (pc, insn) deliveries; a second instance covers the wrapping reset vector.
module tb_ifu_prefetch;
  localparam logic [31:0] K = 32'hA5A5A5A5;

  typedef struct { logic [31:0] pc; logic [31:0] insn; } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, gnt, rdy, redir, hold, extra_rv;
  logic [31:0] redir_pc, extra_data;
  logic        model_rv;
  logic [31:0] model_data;
  logic        rvalid;
  logic [31:0] rdata;
  assign rvalid = model_rv | extra_rv;
  assign rdata  = model_rv ? model_data : extra_data;

  logic        o_mem_req, o_insn_vld, o_err;
  logic [31:0] o_mem_addr, o_insn, o_insn_pc, o_pc_debug;

  logic        w_rv, w_req, w_vld, w_err;
  logic [31:0] w_rdata, w_addr, w_insn, w_pc, w_dbg;

  int checks, errors, gnt_cnt;
  logic [31:0] exp_pc;
  ent_t        exp_q[$];
  logic [31:0] pend_q[$];

  ifu_prefetch #(.XLEN(32), .RESET_VEC(32'h0000_0000), .DEPTH(4)) dut (
    .i_clk(clk), .rst(rst),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_gnt(gnt),
    .i_mem_rvalid(rvalid), .i_mem_rdata(rdata),
    .i_redirect(redir), .i_redirect_pc(redir_pc),
    .o_insn_vld(o_insn_vld), .o_insn(o_insn), .o_insn_pc(o_insn_pc), .i_insn_rdy(rdy),
    .o_pc_debug(o_pc_debug), .o_err(o_err)
  );

  ifu_prefetch #(.XLEN(32), .RESET_VEC(32'hFFFF_FFFC), .DEPTH(4)) dut_w (
    .i_clk(clk), .rst(rst),
    .o_mem_req(w_req), .o_mem_addr(w_addr), .i_mem_gnt(1'b1),
    .i_mem_rvalid(w_rv), .i_mem_rdata(w_rdata),
    .i_redirect(1'b0), .i_redirect_pc(32'h0),
    .o_insn_vld(w_vld), .o_insn(w_insn), .o_insn_pc(w_pc), .i_insn_rdy(1'b1),
    .o_pc_debug(w_dbg), .o_err(w_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model and scoreboard: sample mid-cycle, drive the next response after the edge.
  always begin
    @(negedge clk);
    if (!rst) begin
      exp_q.delete();
      pend_q.delete();
      exp_pc = 32'h0;
    end else begin
      if (o_insn_vld && rdy && !redir) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("sb_pc", o_insn_pc, exp_q[0].pc);
          chk("sb_insn", o_insn, exp_q[0].insn);
          void'(exp_q.pop_front());
        end
      end
      if (redir) exp_q.delete();
      if (model_rv) void'(pend_q.pop_front());
      if (o_mem_req && gnt) begin
        chk("sb_addr", o_mem_addr, exp_pc);
        gnt_cnt++;
        pend_q.push_back(o_mem_addr);
        if (!redir) exp_q.push_back('{exp_pc, exp_pc ^ K});
      end
      if (redir) exp_pc = {redir_pc[31:2], 2'b00};
      else if (o_mem_req && gnt) exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    #2;
    model_rv   = !hold && (pend_q.size() != 0);
    model_data = (pend_q.size() != 0) ? (pend_q[0] ^ K) : 32'h0;
  end

  // Single-cycle-latency responder for the wrap instance.
  logic        w_pv;
  logic [31:0] w_pend;
  always begin
    @(negedge clk);
    w_pv   = w_req;
    w_pend = w_addr;
    @(posedge clk);
    #2;
    w_rv    = w_pv;
    w_rdata = w_pend ^ K;
  end

  initial begin
    int n;
    checks = 0; errors = 0; gnt_cnt = 0;
    rst = 1'b0; gnt = 1'b1; rdy = 1'b0; redir = 1'b0; redir_pc = 32'h0;
    hold = 1'b0; extra_rv = 1'b0; extra_data = 32'h0;
    model_rv = 1'b0; model_data = 32'h0; w_rv = 1'b0; w_rdata = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_req", o_mem_req, 0);
    chk("rst_vld", o_insn_vld, 0);
    chk("rst_err", o_err, 0);
    chk("rst_pc", o_pc_debug, 32'h0);
    chk("rst_wpc", w_dbg, 32'hFFFF_FFFC);

    // Leave reset with the consumer stalled: buffer must fill after exactly 4 grants.
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("first_req", o_mem_req, 1);
    chk("first_addr", o_mem_addr, 32'h0);
    chk("w_addr0", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("w_addr1", w_addr, 32'h0);
    chk("lat_vld0", o_insn_vld, 0);
    chk("w_vld0", w_vld, 0);
    @(negedge clk);
    chk("lat_vld1", o_insn_vld, 1);
    chk("w_vld1", w_vld, 1);
    chk("w_pc0", w_pc, 32'hFFFF_FFFC);
    chk("w_insn0", w_insn, 32'hFFFF_FFFC ^ K);
    @(negedge clk);
    chk("w_pc1", w_pc, 32'h0);
    chk("w_insn1", w_insn, K);
    repeat (4) @(negedge clk);
    chk("grants4", gnt_cnt, 4);
    chk("full_req", o_mem_req, 0);
    chk("full_pc", o_insn_pc, 32'h0);
    chk("full_insn", o_insn, K);

    @(posedge clk); #1; rdy = 1'b1;
    @(negedge clk);
    chk("pop_pc0", o_insn_pc, 32'h0);
    chk("pop_req0", o_mem_req, 0);
    @(negedge clk);
    chk("pop_pc4", o_insn_pc, 32'h4);
    chk("pop_req1", o_mem_req, 1);
    @(negedge clk);
    chk("pop_pc8", o_insn_pc, 32'h8);
    @(negedge clk);
    chk("pop_pcC", o_insn_pc, 32'hC);
    chk("pop_insnC", o_insn, 32'hC ^ K);
    repeat (6) @(negedge clk);

    // Misaligned redirect in the same cycle as a response and a pop.
    @(posedge clk); #1; redir = 1'b1; redir_pc = 32'h103;
    @(negedge clk);
    chk("rd_pre_vld", o_insn_vld, 1);
    chk("rd_pre_rv", rvalid, 1);
    @(posedge clk); #1; redir = 1'b0;
    @(negedge clk);
    chk("rd_vld", o_insn_vld, 0);
    chk("rd_addr", o_mem_addr, 32'h100);
    chk("rd_dbg", o_pc_debug, 32'h100);
    repeat (10) @(negedge clk);

    // Two requests held in flight across a redirect.
    @(posedge clk); #1; gnt = 1'b0;
    repeat (6) @(negedge clk);
    chk("drain_vld", o_insn_vld, 0);
    @(posedge clk); #1; gnt = 1'b1; hold = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; gnt = 1'b0; redir = 1'b1; redir_pc = 32'h100;
    @(posedge clk); #1; redir = 1'b0; hold = 1'b0; gnt = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_insn_vld && n < 20);
    chk("r2_vld", o_insn_vld, 1);
    chk("r2_pc", o_insn_pc, 32'h100);
    chk("r2_insn", o_insn, 32'h100 ^ K);
    repeat (8) @(negedge clk);

    // Fill the buffer, then inject a response with nothing outstanding.
    @(posedge clk); #1; rdy = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk); #1; gnt = 1'b0; extra_rv = 1'b1; extra_data = 32'hDEAD_BEEF;
    @(posedge clk); #1; extra_rv = 1'b0;
    @(negedge clk);
    chk("err_set", o_err, 1);
    chk("err_vld", o_insn_vld, 1);
    chk("err_q4", exp_q.size(), 4);
    if (exp_q.size() != 0) begin
      chk("err_pc", o_insn_pc, exp_q[0].pc);
      chk("err_insn", o_insn, exp_q[0].insn);
    end
    @(posedge clk); #1; rdy = 1'b1;
    repeat (7) @(negedge clk);
    chk("err_drained", o_insn_vld, 0);
    chk("err_sbq", exp_q.size(), 0);
    chk("err_sticky", o_err, 1);

    // Reset with requests still outstanding; a response lands in the reset cycle.
    @(posedge clk); #1; gnt = 1'b1; hold = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1; rst = 1'b0; hold = 1'b0;
    @(negedge clk);
    chk("mr_req", o_mem_req, 0);
    @(negedge clk);
    chk("mr_err", o_err, 0);
    chk("mr_vld", o_insn_vld, 0);
    chk("mr_addr", o_mem_addr, 32'h0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("mr_req1", o_mem_req, 1);
    chk("mr_addr1", o_mem_addr, 32'h0);
    repeat (10) @(negedge clk);
    chk("mr_err_clr", o_err, 0);
    @(posedge clk); #1; gnt = 1'b0;
    repeat (8) @(negedge clk);
    chk("end_vld", o_insn_vld, 0);
    chk("end_sbq", exp_q.size(), 0);
    chk("end_werr", w_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
